// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_pkg
//  Description : Shared constants and types for the HCORDIC pipeline and
//                its issue scheduler: mode encodings, idle encodings, the
//                InsTag width and the operand bundle presented at the
//                pipeline head.
//  Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    localparam int TAG_W  = 8;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        MODE_LINEAR     = 2'b00,
        MODE_CIRCULAR   = 2'b01,
        MODE_HYPERBOLIC = 2'b11
    } cordic_mode_e;

    typedef enum logic [1:0] {
        NO_IDLE     = 2'b00,
        ALLIGN_IDLE = 2'b01,
        PUT_IDLE    = 2'b10
    } cordic_idle_e;

    // One operation as it enters the pipeline head.
    typedef struct packed {
        logic [DATA_W-1:0] sin;
        logic [1:0]        mode;
        logic              operation;
        logic              natlog;
    } cordic_op_t;

endpackage
`default_nettype wire

// File: rtl/cordic_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_rr_arbiter
//  Description : Combinational round-robin arbiter. Finds the first set bit
//                of req starting at rr_ptr and searching upward with wrap.
//                The pointer itself is owned by the caller.
//  Ports       : req       - request vector
//                enable    - when low, no grant is produced
//                rr_ptr    - highest-priority requester this cycle
//                grant     - one-hot grant (all-zero when none)
//                grant_idx - index of the granted requester
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx
);

    always_comb begin
        logic        w_found;
        int unsigned w_idx;
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Modulo keeps the wrap correct for non-power-of-2 NUM_REQ.
            w_idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (enable && !w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                grant_idx    = PTR_W'(w_idx);
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cordic_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_issue_scheduler
//  Description : Shares one HCORDIC pipeline among NUM_REQ requesters.
//                Round-robin grants one request per cycle into the pipeline
//                head, stamps it with a sequential InsTag, records the owner
//                of the tag, limits in-flight ops by a credit count and
//                routes in-order PackSum results back to their owner.
//  Ports       : clock/reset           - clock, async active-high reset
//                req_*                 - flattened per-requester operands
//                req_ready             - combinational one-hot grant
//                issue_*               - registered op to the pipeline head
//                ret_*                 - PackSum result and its InsTag
//                resp_*                - one-cycle result strobe to owner
//                outstanding           - ops currently in flight
//                tag_error             - sticky out-of-order/stray return
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_issue_scheduler
    import cordic_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [32*NUM_REQ-1:0]               req_sin,
    input  logic [2*NUM_REQ-1:0]                req_mode,
    input  logic [NUM_REQ-1:0]                  req_operation,
    input  logic [NUM_REQ-1:0]                  req_natlog,
    output logic                                issue_valid,
    output logic [31:0]                         issue_sin,
    output logic [1:0]                          issue_mode,
    output logic                                issue_operation,
    output logic                                issue_natlog,
    output logic [TAG_W-1:0]                    issue_tag,
    input  logic                                ret_valid,
    input  logic [31:0]                         ret_sout,
    input  logic [TAG_W-1:0]                    ret_tag,
    output logic [NUM_REQ-1:0]                  resp_valid,
    output logic [31:0]                         resp_data,
    output logic [TAG_W-1:0]                    resp_tag,
    output logic [$clog2(MAX_OUTSTANDING):0]    outstanding,
    output logic                                tag_error
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;
    localparam int SLOT_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    // ---------------- arbitration ----------------
    logic                 w_canIssue;
    logic [NUM_REQ-1:0]   w_grant;
    logic [PTR_W-1:0]     w_grantIdx;
    logic                 w_issueAccept;
    logic                 w_retValid;
    logic                 w_retError;
    cordic_op_t           w_reqOp;

    logic [PTR_W-1:0]     r_rrPtr;
    logic [TAG_W-1:0]     r_tagCnt;
    logic [TAG_W-1:0]     r_expTag;
    logic [CNT_W-1:0]     r_outstanding;
    logic                 r_issueValid;
    logic [TAG_W-1:0]     r_issueTag;
    cordic_op_t           r_issueOp;
    logic [NUM_REQ-1:0]   r_respValid;
    logic [31:0]          r_respData;
    logic [TAG_W-1:0]     r_respTag;
    logic                 r_tagError;
    logic [PTR_W-1:0]     r_ownerTbl [2**SLOT_W];

    // A return in this cycle does not free a credit until the next cycle.
    assign w_canIssue = (r_outstanding < C_MAX_CNT);

    cordic_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arbiter (
        .req       (req_valid),
        .enable    (w_canIssue),
        .rr_ptr    (r_rrPtr),
        .grant     (w_grant),
        .grant_idx (w_grantIdx)
    );

    assign req_ready     = w_grant;
    assign w_issueAccept = |w_grant;

    always_comb begin
        w_reqOp.sin       = req_sin[32*int'(w_grantIdx) +: 32];
        w_reqOp.mode      = req_mode[2*int'(w_grantIdx) +: 2];
        w_reqOp.operation = req_operation[w_grantIdx];
        w_reqOp.natlog    = req_natlog[w_grantIdx];
    end

    // Results come back in issue order, so only the next expected tag is
    // acceptable; anything else (including strays after a reset) is an error.
    assign w_retValid = ret_valid && (r_outstanding != '0) && (ret_tag == r_expTag);
    assign w_retError = ret_valid && !w_retValid;

    // ---------------- issue side ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_issueValid <= 1'b0;
            r_issueOp    <= '0;
            r_issueTag   <= '0;
            r_tagCnt     <= '0;
            r_rrPtr      <= '0;
        end else begin
            r_issueValid <= w_issueAccept;
            if (w_issueAccept) begin
                r_issueOp  <= w_reqOp;
                r_issueTag <= r_tagCnt;
                r_tagCnt   <= r_tagCnt + TAG_W'(1);
                r_rrPtr    <= (w_grantIdx == PTR_W'(NUM_REQ - 1)) ? '0
                                                                  : w_grantIdx + PTR_W'(1);
            end
        end
    end

    // Tag slots cannot collide: at most MAX_OUTSTANDING tags are live and
    // the slot index is the tag modulo MAX_OUTSTANDING.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2**SLOT_W; i++) begin
                r_ownerTbl[i] <= '0;
            end
        end else if (w_issueAccept) begin
            r_ownerTbl[r_tagCnt[SLOT_W-1:0]] <= w_grantIdx;
        end
    end

    // ---------------- return side ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_respValid   <= '0;
            r_respData    <= '0;
            r_respTag     <= '0;
            r_expTag      <= '0;
            r_tagError    <= 1'b0;
            r_outstanding <= '0;
        end else begin
            r_respValid <= '0;
            if (w_retValid) begin
                r_respValid <= NUM_REQ'(1) << r_ownerTbl[ret_tag[SLOT_W-1:0]];
                r_respData  <= ret_sout;
                r_respTag   <= ret_tag;
                r_expTag    <= r_expTag + TAG_W'(1);
            end
            if (w_retError) begin
                r_tagError <= 1'b1;
            end
            case ({w_issueAccept, w_retValid})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign issue_valid     = r_issueValid;
    assign issue_sin       = r_issueOp.sin;
    assign issue_mode      = r_issueOp.mode;
    assign issue_operation = r_issueOp.operation;
    assign issue_natlog    = r_issueOp.natlog;
    assign issue_tag       = r_issueTag;
    assign resp_valid      = r_respValid;
    assign resp_data       = r_respData;
    assign resp_tag        = r_respTag;
    assign outstanding     = r_outstanding;
    assign tag_error       = r_tagError;

endmodule
`default_nettype wire

// File: tb/tb_cordic_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_issue_scheduler
//  Description : Directed self-checking bench for cordic_issue_scheduler
//                (NUM_REQ=4, MAX_OUTSTANDING=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_issue_scheduler;

    localparam int NR = 4;
    localparam int MO = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [32*NR-1:0] req_sin;
    logic [2*NR-1:0]  req_mode;
    logic [NR-1:0] req_operation;
    logic [NR-1:0] req_natlog;
    logic          issue_valid;
    logic [31:0]   issue_sin;
    logic [1:0]    issue_mode;
    logic          issue_operation;
    logic          issue_natlog;
    logic [7:0]    issue_tag;
    logic          ret_valid;
    logic [31:0]   ret_sout;
    logic [7:0]    ret_tag;
    logic [NR-1:0] resp_valid;
    logic [31:0]   resp_data;
    logic [7:0]    resp_tag;
    logic [4:0]    outstanding;
    logic          tag_error;

    int nvec = 0;
    int nerr = 0;

    cordic_issue_scheduler #(
        .NUM_REQ         (NR),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_sin         (req_sin),
        .req_mode        (req_mode),
        .req_operation   (req_operation),
        .req_natlog      (req_natlog),
        .issue_valid     (issue_valid),
        .issue_sin       (issue_sin),
        .issue_mode      (issue_mode),
        .issue_operation (issue_operation),
        .issue_natlog    (issue_natlog),
        .issue_tag       (issue_tag),
        .ret_valid       (ret_valid),
        .ret_sout        (ret_sout),
        .ret_tag         (ret_tag),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_tag        (resp_tag),
        .outstanding     (outstanding),
        .tag_error       (tag_error)
    );

    always #5 clock = ~clock;

    task automatic idle_inputs();
        req_valid = '0; req_sin = '0; req_mode = '0; req_operation = '0; req_natlog = '0;
        ret_valid = 1'b0; ret_sout = '0; ret_tag = '0;
    endtask

    // Registered outputs are checked 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++; if (issue_valid !== 1'b0) begin nerr++; $display("FAIL reset_issue_valid: got %b want 0", issue_valid); end
        nvec++; if (resp_valid !== 4'b0) begin nerr++; $display("FAIL reset_resp_valid: got %b want 0000", resp_valid); end
        nvec++; if (outstanding !== 5'd0) begin nerr++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        nvec++; if (tag_error !== 1'b0) begin nerr++; $display("FAIL reset_tag_error: got %b want 0", tag_error); end
        nvec++; if (issue_tag !== 8'd0) begin nerr++; $display("FAIL reset_issue_tag: got %0d want 0", issue_tag); end
        // Asynchronous reset taking effect mid-cycle, with no clock edge.
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        nvec++; if (outstanding !== 5'd1) begin nerr++; $display("FAIL pre_async_outstanding: got %0d want 1", outstanding); end
        #2 reset = 1'b1;
        #1;
        nvec++; if (outstanding !== 5'd0 || issue_valid !== 1'b0) begin nerr++; $display("FAIL async_reset: got out=%0d iv=%b want 0/0", outstanding, issue_valid); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0100;
        req_sin[95:64] = 32'h3F80_0000;
        req_mode[5:4] = 2'b01;
        req_operation[2] = 1'b1;
        #1;
        nvec++; if (req_ready !== 4'b0100) begin nerr++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        step();
        req_valid = '0;
        nvec++; if (issue_valid !== 1'b1 || issue_tag !== 8'd0) begin nerr++; $display("FAIL single_issue: got v=%b tag=%0d want 1/0", issue_valid, issue_tag); end
        nvec++; if (issue_sin !== 32'h3F80_0000 || issue_mode !== 2'b01 || issue_operation !== 1'b1 || issue_natlog !== 1'b0) begin nerr++; $display("FAIL single_fields: got %h/%b/%b/%b want 3f800000/01/1/0", issue_sin, issue_mode, issue_operation, issue_natlog); end
        nvec++; if (outstanding !== 5'd1) begin nerr++; $display("FAIL single_outstanding: got %0d want 1", outstanding); end
        ret_valid = 1'b1; ret_tag = 8'd0; ret_sout = 32'h3F35_04F3;
        step();
        ret_valid = 1'b0;
        nvec++; if (resp_valid !== 4'b0100 || resp_data !== 32'h3F35_04F3 || resp_tag !== 8'd0) begin nerr++; $display("FAIL single_resp: got %b/%h/%0d want 0100/3f3504f3/0", resp_valid, resp_data, resp_tag); end
        nvec++; if (outstanding !== 5'd0 || issue_valid !== 1'b0) begin nerr++; $display("FAIL single_drain: got out=%0d iv=%b want 0/0", outstanding, issue_valid); end
        step();
        nvec++; if (resp_valid !== 4'b0) begin nerr++; $display("FAIL single_resp_pulse: got %b want 0000", resp_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = 4'hF;
        for (int i = 0; i < NR; i++) begin
            req_sin[32*i +: 32] = 32'hA000_0000 + i;
            req_mode[2*i +: 2]  = 2'(i);
        end
        for (int k = 0; k < 8; k++) begin
            #1;
            nvec++; if (req_ready !== (4'b0001 << (k % 4))) begin nerr++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, 4'b0001 << (k % 4)); end
            step();
            nvec++; if (issue_valid !== 1'b1 || issue_tag !== 8'(k) || issue_sin !== 32'hA000_0000 + 32'(k % 4) || issue_mode !== 2'(k % 4)) begin nerr++; $display("FAIL rr_issue[%0d]: got v=%b tag=%0d sin=%h mode=%b", k, issue_valid, issue_tag, issue_sin, issue_mode); end
        end
        req_valid = '0;
        nvec++; if (outstanding !== 5'd8) begin nerr++; $display("FAIL rr_outstanding: got %0d want 8", outstanding); end
    endtask

    task automatic test_credit();
        do_reset();
        req_valid = 4'b0001;
        repeat (16) step();
        #1;
        nvec++; if (outstanding !== 5'd16 || req_ready !== 4'b0) begin nerr++; $display("FAIL credit_full: got out=%0d rdy=%b want 16/0000", outstanding, req_ready); end
        ret_valid = 1'b1; ret_tag = 8'd0; ret_sout = 32'h0000_0000;
        #1;
        nvec++; if (req_ready !== 4'b0) begin nerr++; $display("FAIL credit_same_cycle: got %b want 0000", req_ready); end
        step();
        ret_valid = 1'b0;
        nvec++; if (outstanding !== 5'd15 || resp_valid !== 4'b0001) begin nerr++; $display("FAIL credit_return: got out=%0d resp=%b want 15/0001", outstanding, resp_valid); end
        #1;
        nvec++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL credit_regrant: got %b want 0001", req_ready); end
        step();
        req_valid = '0;
        nvec++; if (outstanding !== 5'd16 || issue_tag !== 8'd16) begin nerr++; $display("FAIL credit_reissue: got out=%0d tag=%0d want 16/16", outstanding, issue_tag); end
    endtask

    task automatic test_tag_wrap();
        do_reset();
        for (int k = 0; k < 300; k++) begin
            req_valid = 4'b0001 << (k % 4);
            req_sin[32*(k % 4) +: 32] = 32'h4000_0000 + 32'(k);
            ret_valid = (k > 0);
            ret_tag   = 8'(k - 1);
            ret_sout  = 32'hC000_0000 + 32'(k - 1);
            step();
            nvec++; if (issue_valid !== 1'b1 || issue_tag !== 8'(k) || issue_sin !== 32'h4000_0000 + 32'(k)) begin nerr++; $display("FAIL wrap_issue[%0d]: got v=%b tag=%0d sin=%h", k, issue_valid, issue_tag, issue_sin); end
            if (k > 0) begin
                nvec++; if (resp_valid !== (4'b0001 << ((k - 1) % 4)) || resp_tag !== 8'(k - 1) || resp_data !== 32'hC000_0000 + 32'(k - 1) || outstanding !== 5'd1) begin nerr++; $display("FAIL wrap_resp[%0d]: got %b/%0d/%h out=%0d", k - 1, resp_valid, resp_tag, resp_data, outstanding); end
            end
        end
        req_valid = '0;
        ret_valid = 1'b1; ret_tag = 8'(299); ret_sout = 32'hC000_0000 + 32'd299;
        step();
        ret_valid = 1'b0;
        nvec++; if (resp_valid !== 4'b1000 || resp_tag !== 8'd43 || outstanding !== 5'd0 || tag_error !== 1'b0) begin nerr++; $display("FAIL wrap_final: got %b/%0d out=%0d err=%b want 1000/43/0/0", resp_valid, resp_tag, outstanding, tag_error); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req_valid = 4'b0010;
        req_sin[63:32] = 32'h1111_1111;
        repeat (5) step();
        req_valid = '0;
        #1;
        nvec++; if (outstanding !== 5'd5) begin nerr++; $display("FAIL simul_pre: got %0d want 5", outstanding); end
        req_valid = 4'b1000;
        req_sin[127:96] = 32'h2222_2222;
        ret_valid = 1'b1; ret_tag = 8'd0; ret_sout = 32'h7F80_0000;
        step();
        idle_inputs();
        nvec++; if (outstanding !== 5'd5) begin nerr++; $display("FAIL simul_count: got %0d want 5", outstanding); end
        nvec++; if (issue_valid !== 1'b1 || issue_tag !== 8'd5 || issue_sin !== 32'h2222_2222) begin nerr++; $display("FAIL simul_issue: got v=%b tag=%0d sin=%h want 1/5/22222222", issue_valid, issue_tag, issue_sin); end
        nvec++; if (resp_valid !== 4'b0010 || resp_data !== 32'h7F80_0000 || resp_tag !== 8'd0) begin nerr++; $display("FAIL simul_resp: got %b/%h/%0d want 0010/7f800000/0", resp_valid, resp_data, resp_tag); end
    endtask

    task automatic test_errors();
        do_reset();
        ret_valid = 1'b1; ret_tag = 8'd0; ret_sout = 32'h1234_5678;
        step();
        ret_valid = 1'b0;
        nvec++; if (tag_error !== 1'b1 || resp_valid !== 4'b0 || outstanding !== 5'd0) begin nerr++; $display("FAIL err_empty: got err=%b resp=%b out=%0d want 1/0000/0", tag_error, resp_valid, outstanding); end
        step();
        nvec++; if (tag_error !== 1'b1) begin nerr++; $display("FAIL err_sticky: got %b want 1", tag_error); end
        do_reset();
        nvec++; if (tag_error !== 1'b0) begin nerr++; $display("FAIL err_cleared: got %b want 0", tag_error); end
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        ret_valid = 1'b1; ret_tag = 8'd3; ret_sout = 32'h1234_5678;
        step();
        ret_valid = 1'b0;
        nvec++; if (tag_error !== 1'b1 || outstanding !== 5'd1 || resp_valid !== 4'b0) begin nerr++; $display("FAIL err_mismatch: got err=%b out=%0d resp=%b want 1/1/0000", tag_error, outstanding, resp_valid); end
        ret_valid = 1'b1; ret_tag = 8'd0; ret_sout = 32'h8000_0000;
        step();
        ret_valid = 1'b0;
        nvec++; if (resp_valid !== 4'b0001 || resp_data !== 32'h8000_0000 || outstanding !== 5'd0) begin nerr++; $display("FAIL err_recover: got %b/%h out=%0d want 0001/80000000/0", resp_valid, resp_data, outstanding); end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_credit();
        test_tag_wrap();
        test_simultaneous();
        test_errors();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cordic_issue_scheduler.md
Name: cordic_issue_scheduler

Overview:
Shares one HCORDIC pipeline among NUM_REQ requesters. Each cycle it round-robin arbitrates one request into the pipeline head and stamps it with a unique InsTag. It tracks the owner of each tag in flight and limits in-flight operations by a credit count. When a result leaves the PackSum stage, it routes that result back to the owning requester.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_OUTSTANDING, 16, max ops in flight; power of 2, <= 128
TAG_W, 8, InsTag width; fixed to match pipeline InsTag

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
req_valid  in  NUM_REQ  per-requester request
req_ready  out  NUM_REQ  one-hot grant (combinational)
req_sin  in  32*NUM_REQ  flattened IEEE-754 operand, requester i at [32i+31:32i]
req_mode  in  2*NUM_REQ  CORDIC mode per requester
req_operation  in  NUM_REQ  operation bit per requester
req_natlog  in  NUM_REQ  NatLog flag per requester
issue_valid  out  1  op presented to pipeline head
issue_sin  out  32  operand
issue_mode  out  2  mode
issue_operation  out  1  operation
issue_natlog  out  1  NatLog flag
issue_tag  out  8  assigned InsTag
ret_valid  in  1  PackSum result valid
ret_sout  in  32  sout_PackSum
ret_tag  in  8  InsTag_PackSum
resp_valid  out  NUM_REQ  one-hot result strobe to owner
resp_data  out  32  result word, shared by all requesters
resp_tag  out  8  tag of returned result
outstanding  out  log2(MAX_OUTSTANDING)+1  in-flight count
tag_error  out  1  sticky protocol error

Behaviour:
- Reset is asynchronous: every output and register clears to 0, including rr pointer, tag counter, expected-return tag, outstanding count and tag_error.
- Credit: can_issue = (outstanding < MAX_OUTSTANDING). A return in the same cycle does not add a credit in that cycle.
- Arbitration: when can_issue is set, req_ready is one-hot for the first i with req_valid[i]=1, searching from rr_ptr upward with wrap. req_ready is all-zero when no request is pending or can_issue=0.
- On a grant to i: rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Handshake req_valid[i] & req_ready[i] in cycle N:
  - cycle N+1: issue_valid=1, and issue_* carry requester i's fields plus issue_tag=tag_cnt.
  - owner_tbl[tag_cnt mod MAX_OUTSTANDING] <= i.
  - tag_cnt <= tag_cnt+1, wrapping 255->0.
- With no grant, issue_valid=0 next cycle. issue_* data hold their last values.
- The pipeline has no backpressure, so an issue is never stalled or retracted.
- Returns arrive in issue order. A return is valid when ret_valid=1, outstanding != 0 and ret_tag == exp_tag. In cycle M such a return gives:
  - cycle M+1: resp_valid = onehot(owner_tbl[ret_tag mod MAX_OUTSTANDING]), resp_data=ret_sout, resp_tag=ret_tag.
  - exp_tag <= exp_tag+1.
- Invalid return (ret_valid=1 with outstanding==0, or tag mismatch):
  - tag_error <= 1, sticky until reset.
  - no resp_valid; exp_tag and outstanding unchanged.
- Count update: outstanding <= outstanding + issue_accept - valid_return. Simultaneous issue and return leaves the count unchanged. The count never exceeds MAX_OUTSTANDING and never underflows.
- Tag reuse is safe because MAX_OUTSTANDING <= 128 < 256: a live tag is never re-issued.
- resp_valid is a single-cycle pulse. Requesters must sink it and cannot stall it.
- Reset mid-operation: all tracking is discarded. Any pipeline result returning after reset is counted as a protocol error (tag_error=1) and dropped.
- ret_sout is passed through untouched, including ±inf (exponent 255) and zero encodings.

Decomposition:
- Shared package cordic_pkg:
  - MODE_CIRCULAR=2'b01, MODE_LINEAR=2'b00, MODE_HYPERBOLIC=2'b11.
  - NO_IDLE=2'b00, ALLIGN_IDLE=2'b01, PUT_IDLE=2'b10.
  - TAG_W=8.
- One sub-module, cordic_rr_arbiter. Inputs: req, enable, rr_ptr. Outputs: one-hot grant and the grant index. Purely combinational; the scheduler owns rr_ptr.

Test Plan:
- Reset then single request: req_valid=4'b0100, sin=32'h3F800000, mode=01. Expect req_ready=4'b0100 the same cycle; next cycle issue_valid=1, issue_tag=0, issue_sin=3F800000, outstanding=1. Then ret_valid with tag 0, sout=32'h3F3504F3 -> next cycle resp_valid=4'b0100, resp_data=3F3504F3, outstanding=0.
- All four requesters held valid for 8 cycles, no returns. Grants go 0,1,2,3,0,1,2,3; issue_tag 0..7; outstanding=8.
- Credit limit: 16 issues with no returns. Expect outstanding=16 and req_ready=0 on cycle 17. A return with tag 0 re-enables the grant the following cycle.
- Tag wrap: 300 ops issued and returned in order at steady state. issue_tag goes 255->0, every resp_valid hits the correct owner, tag_error stays 0.
- Simultaneous issue and return in one cycle with outstanding=5: outstanding stays 5, and resp and issue both appear next cycle.
- Error cases: ret_valid with outstanding=0 gives tag_error=1 and no resp_valid. After reset, a return with ret_tag=3 when exp_tag=0 gives tag_error=1 and outstanding unchanged.
